// File: rtl/reg_bank.sv
// reg_bank: 32 x WIDTH MIPS general-purpose register file.
// It has two registered read ports, one write port and a serial dump port
// with a valid/ready handshake.
// Optional feature macro: REG_BANK_BYPASS_EN. When it is defined, a write
// issued in the same cycle is forwarded to a read port that addresses the
// same register.
module reg_bank #(
    parameter int SP_RESET = 227,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_write,
    input  logic [4:0]       regDest,
    input  logic [WIDTH-1:0] write_data,
    input  logic [4:0]       RS,
    input  logic [4:0]       RT,
    output logic [WIDTH-1:0] read_data_a,
    output logic [WIDTH-1:0] read_data_b,
    input  logic             dump_start,
    input  logic             dump_ready,
    output logic             dump_valid,
    output logic [4:0]       dump_index,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state, state_nxt;
    logic [4:0]       idx, idx_nxt;
    logic [WIDTH-1:0] regs [32];
    logic [WIDTH-1:0] rs_val, rt_val;
    logic             wr_en;
    logic             byp_a, byp_b;

    // Address 0 is hard-wired to zero, so writes to it are dropped here.
    assign wr_en = reg_write && (regDest != 5'd0);

`ifdef REG_BANK_BYPASS_EN
    assign byp_a = wr_en && (regDest == RS);
    assign byp_b = wr_en && (regDest == RT);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    // Combinational read muxes. Register 0 is forced to zero independently of its storage.
    always_comb begin
        rs_val    = (RS  == 5'd0) ? '0 : regs[RS];
        rt_val    = (RT  == 5'd0) ? '0 : regs[RT];
        dump_data = (idx == 5'd0) ? '0 : regs[idx];
    end

    // Register storage: reset values (sp preset), then the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[29] <= WIDTH'(SP_RESET);
        end else if (wr_en) begin
            regs[regDest] <= write_data;
        end
    end

    // Registered read ports feeding the A/B operand latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_a <= '0;
            read_data_b <= '0;
        end else begin
            read_data_a <= byp_a ? write_data : rs_val;
            read_data_b <= byp_b ? write_data : rt_val;
        end
    end

    // Dump FSM state and index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 5'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Dump next-state and handshake outputs. Valid is held in SEND until a transfer occurs.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = SEND;
                    idx_nxt   = 5'd0;
                end
            end
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (idx == 5'd31) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            DONE: begin
                dump_done = 1'b1;
                dump_busy = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dump_index = idx;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: bench for reg_bank, driven by directed stimulus.
// A register-array and dump-position model is checked against the DUT on every cycle.
// Hand-computed literal checks also pin down the model itself.
module tb_reg_bank;

    localparam int W  = 32;
    localparam int SP = 227;

    logic         clk = 1'b0;
    logic         reset, reg_write, dump_start, dump_ready;
    logic [4:0]   regDest, RS, RT;
    logic [W-1:0] write_data;
    logic [W-1:0] read_data_a, read_data_b, dump_data;
    logic         dump_valid, dump_busy, dump_done;
    logic [4:0]   dump_index;

    reg_bank #(.SP_RESET(SP), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .regDest(regDest),
        .write_data(write_data), .RS(RS), .RT(RT),
        .read_data_a(read_data_a), .read_data_b(read_data_b),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_index(dump_index), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    // Model state. The register file is a plain array. pos is -1 when idle,
    // 0..31 for the word being offered, and 32 for the done cycle.
    logic [W-1:0] m [32];
    logic [W-1:0] exp_a, exp_b;
    int           pos;
    bit           live = 1'b0;

    int errors = 0, checks = 0;
    // Observed handshake statistics, taken from the DUT pins.
    int busy_cyc = 0, done_cnt = 0, xfer_cnt = 0, nz_cnt = 0;
    logic [W-1:0] last31 = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("rd_a", read_data_a, exp_a);
        check("rd_b", read_data_b, exp_b);
        check("dump_valid", W'(dump_valid), W'(pos >= 0 && pos <= 31));
        check("dump_busy",  W'(dump_busy),  W'(pos >= 0));
        check("dump_done",  W'(dump_done),  W'(pos == 32));
        if (pos >= 0 && pos <= 31) begin
            check("dump_index", W'(dump_index), W'(pos));
            check("dump_data", dump_data, m[pos]);
        end
        if (dump_busy) busy_cyc++;
        if (dump_done) done_cnt++;
        if (dump_valid && dump_ready) begin
            xfer_cnt++;
            if (dump_data != '0) nz_cnt++;
            if (dump_index == 5'd31) last31 = dump_data;
        end
    endtask

    // Apply one rising edge to the model, using the inputs as they stood before the edge.
    task automatic model_edge();
        if (reset) begin
            foreach (m[i]) m[i] = '0;
            m[29] = W'(SP);
            exp_a = '0;
            exp_b = '0;
            pos   = -1;
        end else begin
            exp_a = m[RS];
            exp_b = m[RT];
`ifdef REG_BANK_BYPASS_EN
            if (reg_write && regDest != 0 && regDest == RS) exp_a = write_data;
            if (reg_write && regDest != 0 && regDest == RT) exp_b = write_data;
`endif
            if (pos == 32)                pos = -1;
            else if (pos >= 0)            pos = dump_ready ? pos + 1 : pos;
            else if (dump_start)          pos = 0;
            if (reg_write && regDest != 0) m[regDest] = write_data;
        end
    endtask

    // One clock cycle. Outputs are compared at the falling edge and the model
    // steps at the rising edge. Stimulus changes 2 time units after the rising edge.
    task automatic step();
        @(negedge clk);
        if (live) compare();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    int  b0, d0, x0, n0;
    bit  wrote, seen;

    initial begin
        reset = 1'b1; reg_write = 1'b0; regDest = '0; write_data = '0;
        RS = '0; RT = '0; dump_start = 1'b0; dump_ready = 1'b0;
        step();
        live = 1'b1;
        step();
        check("reset valid", W'(dump_valid), '0);
        check("reset busy",  W'(dump_busy),  '0);
        check("reset done",  W'(dump_done),  '0);
        check("reset index", W'(dump_index), '0);
        check("reset rd_a",  read_data_a,    '0);
        reset = 1'b0;

        // The stack pointer preset and register 0 after reset.
        RS = 5'd29; RT = 5'd0;
        step();
        check("sp reset", read_data_a, 32'd227);
        check("r0 reset", read_data_b, 32'd0);

        // Full dump with the consumer always ready.
        b0 = busy_cyc; d0 = done_cnt; x0 = xfer_cnt; n0 = nz_cnt;
        dump_ready = 1'b1; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        repeat (40) step();
        check("dump1 busy cycles", W'(busy_cyc - b0), 32'd33);
        check("dump1 done pulses", W'(done_cnt - d0), 32'd1);
        check("dump1 transfers",   W'(xfer_cnt - x0), 32'd32);
        check("dump1 nonzero",     W'(nz_cnt - n0),   32'd1);
        dump_ready = 1'b0;

        // Write, then read back. A write to register 0 is discarded.
        reg_write = 1'b1; regDest = 5'd8; write_data = 32'hDEADBEEF;
        step();
        reg_write = 1'b0; RS = 5'd8;
        step();
        check("r8 readback", read_data_a, 32'hDEADBEEF);
        reg_write = 1'b1; regDest = 5'd0; write_data = 32'd5;
        step();
        reg_write = 1'b0; RS = 5'd0;
        step();
        check("r0 write dropped", read_data_a, 32'd0);

        // A write to register 9 and a read of it in the same cycle.
        RS = 5'd9; RT = 5'd9; reg_write = 1'b1; regDest = 5'd9; write_data = 32'h1234;
        step();
        reg_write = 1'b0;
`ifdef REG_BANK_BYPASS_EN
        check("same-cycle r9", read_data_a, 32'h1234);
`else
        check("same-cycle r9", read_data_a, 32'h0);
`endif
        step();
        check("next-cycle r9", read_data_a, 32'h1234);

        // Dump with a toggling ready. reg[31] is written at index 10, and start pulses are ignored while busy.
        d0 = done_cnt; x0 = xfer_cnt; wrote = 1'b0; seen = 1'b0;
        dump_start = 1'b1;
        step();
        for (int i = 0; i < 300 && !seen; i++) begin
            dump_ready = i[0];
            dump_start = (i % 7 == 3);
            if (!wrote && dump_valid && dump_index == 5'd10) begin
                reg_write = 1'b1; regDest = 5'd31; write_data = 32'h55; wrote = 1'b1;
            end else begin
                reg_write = 1'b0;
            end
            step();
            seen = dump_done;
        end
        dump_start = 1'b0; reg_write = 1'b0; dump_ready = 1'b0;
        check("dump2 finished", W'(seen), 32'd1);
        repeat (3) step();
        check("dump2 r31 word",    last31,            32'h55);
        check("dump2 transfers",   W'(xfer_cnt - x0), 32'd32);
        check("dump2 done pulses", W'(done_cnt - d0), 32'd1);

        // Reset arrives in the middle of a dump, at index 15.
        dump_ready = 1'b1; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (dump_valid && dump_index == 5'd15) seen = 1'b1;
            else step();
        end
        check("reached index 15", W'(seen), 32'd1);
        d0 = done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort valid", W'(dump_valid), '0);
        check("abort busy",  W'(dump_busy),  '0);
        RS = 5'd29; RT = 5'd8;
        step();
        check("sp after abort", read_data_a, 32'd227);
        check("r8 after abort", read_data_b, 32'd0);
        repeat (3) step();
        check("abort no done", W'(done_cnt - d0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
